// File: rtl/sorted_serializer_pkg.sv
// Shared configuration for the sorting network output path: default sizes and derived widths.
package sorted_serializer_pkg;

  localparam int unsigned DEF_P_LOG = 7;
  localparam int unsigned DEF_WIDTH = 32;

  // FIFO occupancy: 0, 1 or 2 blocks
  typedef logic [1:0] blk_cnt_t;

  // Number of lanes in one block
  function automatic int unsigned lanes_of(input int unsigned p_log);
    return 32'(1) << p_log;
  endfunction

  // Width of one packed block
  function automatic int unsigned blk_w_of(input int unsigned width, input int unsigned p_log);
    return width << p_log;
  endfunction

endpackage

// File: rtl/sorted_serializer_blk_fifo2.sv
// Two-entry block FIFO; the caller only pushes when the push is accepted (not full, or popping).
module blk_fifo2
  import sorted_serializer_pkg::*;
#(
  parameter int unsigned BLK_W = blk_w_of(DEF_WIDTH, DEF_P_LOG)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [BLK_W-1:0] din_i,
  input  logic             pop_i,
  output logic [BLK_W-1:0] head_o,
  output blk_cnt_t         count_o,
  output logic             full_o
);

  logic [BLK_W-1:0] slot_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  blk_cnt_t         count_q, count_d;

  // Next pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ~wr_ptr_q;
    if (pop_i)  rd_ptr_d = ~rd_ptr_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Block storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (push_i) slot_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = slot_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == 2'd2);

endmodule

// File: rtl/sorted_serializer.sv
// Buffers up to two sorted blocks and streams their lanes, lowest first, over valid/ready.
module sorted_serializer
  import sorted_serializer_pkg::*;
#(
  parameter int unsigned P_LOG = DEF_P_LOG,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [(WIDTH<<P_LOG)-1:0] DIN,
  input  logic                      DINEN,
  input  logic                      DORDY,
  output logic [WIDTH-1:0]          DOT,
  output logic                      DOTEN,
  output logic                      LAST,
  output logic                      FULL,
  output logic                      OVF
);

  localparam int unsigned LANES = lanes_of(P_LOG);
  localparam int unsigned BLK_W = blk_w_of(WIDTH, P_LOG);
  localparam logic [P_LOG-1:0] IDX_MAX = P_LOG'(LANES - 1);

  logic [BLK_W-1:0] head;
  blk_cnt_t         count;
  logic             full;
  logic [P_LOG-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic             valid_c, last_c, beat_c, pop_c, accept_c;

  blk_fifo2 #(.BLK_W(BLK_W)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (accept_c),
    .din_i   (DIN),
    .pop_i   (pop_c),
    .head_o  (head),
    .count_o (count),
    .full_o  (full)
  );

  // Handshake decode; a full buffer still accepts when the head block retires this cycle
  always_comb begin
    valid_c  = (count != '0);
    last_c   = valid_c && (idx_q == IDX_MAX);
    beat_c   = valid_c && DORDY;
    pop_c    = beat_c && last_c;
    accept_c = DINEN && (!full || pop_c);
  end

  // Lane index advance and sticky overflow
  always_comb begin
    idx_d = idx_q;
    ovf_d = ovf_q;
    if (beat_c) idx_d = last_c ? '0 : idx_q + P_LOG'(1);
    if (DINEN && !accept_c) ovf_d = 1'b1;
  end

  // Lane position and overflow flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  end

  assign DOT   = head[32'(idx_q) * WIDTH +: WIDTH];
  assign DOTEN = valid_c;
  assign LAST  = last_c;
  assign FULL  = full;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_sorted_serializer.sv
// Self-checking bench for sorted_serializer with P_LOG=2, WIDTH=8.
module tb_sorted_serializer;

  localparam int unsigned P_LOG = 2;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned LANES = 4;

  logic        clk;
  logic        RST;
  logic [31:0] DIN;
  logic        DINEN;
  logic        DORDY;
  logic [7:0]  DOT;
  logic        DOTEN;
  logic        LAST;
  logic        FULL;
  logic        OVF;

  sorted_serializer #(.P_LOG(P_LOG), .WIDTH(WIDTH)) dut (
    .CLK   (clk),
    .RST   (RST),
    .DIN   (DIN),
    .DINEN (DINEN),
    .DORDY (DORDY),
    .DOT   (DOT),
    .DOTEN (DOTEN),
    .LAST  (LAST),
    .FULL  (FULL),
    .OVF   (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] din;
    logic        dinen;
    logic        dordy;
    logic        chk;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic        ef;
    logic        eo;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  bit          chk_en   = 0;

  // Reference model state
  logic [7:0]  sb_q[$];
  int unsigned m_cnt = 0;
  int unsigned m_idx = 0;
  bit          m_ovf = 0;
  int unsigned drained = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: check outputs against the model, drive inputs, advance the model.
  task automatic cycle(input logic rst, input logic [31:0] din, input logic dinen, input logic dordy);
    bit beat, pop, acc;
    logic [7:0] lane;
    if (chk_en) begin
      chk("DOTEN", 32'(DOTEN), 32'(m_cnt != 0));
      chk("FULL", 32'(FULL), 32'(m_cnt == 2));
      chk("OVF", 32'(OVF), 32'(m_ovf));
      chk("LAST", 32'(LAST), 32'((m_cnt != 0) && (m_idx == LANES - 1)));
      if (m_cnt != 0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL scoreboard_empty: DOT %0h with no expected element", DOT);
        end else begin
          chk("DOT", 32'(DOT), 32'(sb_q[0]));
        end
      end
    end
    RST   = rst;
    DIN   = din;
    DINEN = dinen;
    DORDY = dordy;
    if (rst) begin
      sb_q.delete();
      m_cnt = 0;
      m_idx = 0;
      m_ovf = 0;
    end else begin
      beat = (m_cnt != 0) && dordy;
      pop  = beat && (m_idx == LANES - 1);
      if (beat) begin
        void'(sb_q.pop_front());
        drained++;
        m_idx = pop ? 0 : m_idx + 1;
      end
      acc = dinen && ((m_cnt < 2) || pop);
      if (acc) begin
        for (int i = 0; i < LANES; i++) begin
          lane = din[i*8 +: 8];
          sb_q.push_back(lane);
        end
      end
      if (dinen && !acc) m_ovf = 1;
      if (acc && !pop) m_cnt++;
      else if (pop && !acc) m_cnt--;
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(logic rst, logic [31:0] din, logic dinen, logic dordy, logic c,
                              logic ev, logic [7:0] ed, logic el, logic ef, logic eo);
    vec_t v;
    v.rst = rst; v.din = din; v.dinen = dinen; v.dordy = dordy; v.chk = c;
    v.ev = ev; v.ed = ed; v.el = el; v.ef = ef; v.eo = eo;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    RST = 1'b1; DIN = '0; DINEN = 1'b0; DORDY = 1'b0;

    // Single block at full rate, then two back-to-back blocks
    tbl[0]  = mk(1, 32'h0,        0, 0, 0, 0, 8'd0, 0, 0, 0);
    tbl[1]  = mk(0, 32'h04030201, 1, 1, 1, 0, 8'd0, 0, 0, 0);
    tbl[2]  = mk(0, 32'h0,        0, 1, 1, 1, 8'd1, 0, 0, 0);
    tbl[3]  = mk(0, 32'h0,        0, 1, 1, 1, 8'd2, 0, 0, 0);
    tbl[4]  = mk(0, 32'h0,        0, 1, 1, 1, 8'd3, 0, 0, 0);
    tbl[5]  = mk(0, 32'h0,        0, 1, 1, 1, 8'd4, 1, 0, 0);
    tbl[6]  = mk(0, 32'h04030201, 1, 1, 1, 0, 8'd0, 0, 0, 0);
    tbl[7]  = mk(0, 32'h08070605, 1, 1, 1, 1, 8'd1, 0, 0, 0);
    tbl[8]  = mk(0, 32'h0,        0, 1, 1, 1, 8'd2, 0, 1, 0);
    tbl[9]  = mk(0, 32'h0,        0, 1, 1, 1, 8'd3, 0, 1, 0);
    tbl[10] = mk(0, 32'h0,        0, 1, 1, 1, 8'd4, 1, 1, 0);
    tbl[11] = mk(0, 32'h0,        0, 1, 1, 1, 8'd5, 0, 0, 0);
    tbl[12] = mk(0, 32'h0,        0, 1, 1, 1, 8'd6, 0, 0, 0);
    tbl[13] = mk(0, 32'h0,        0, 1, 1, 1, 8'd7, 0, 0, 0);
    tbl[14] = mk(0, 32'h0,        0, 1, 1, 1, 8'd8, 1, 0, 0);
    tbl[15] = mk(0, 32'h0,        0, 1, 1, 0, 8'd0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_DOTEN", i), 32'(DOTEN), 32'(tbl[i].ev));
        chk($sformatf("tbl%0d_LAST", i), 32'(LAST), 32'(tbl[i].el));
        chk($sformatf("tbl%0d_FULL", i), 32'(FULL), 32'(tbl[i].ef));
        chk($sformatf("tbl%0d_OVF", i), 32'(OVF), 32'(tbl[i].eo));
        if (tbl[i].ev) chk($sformatf("tbl%0d_DOT", i), 32'(DOT), 32'(tbl[i].ed));
      end
      cycle(tbl[i].rst, tbl[i].din, tbl[i].dinen, tbl[i].dordy);
      if (i == 0) chk_en = 1;
    end

    // DORDY toggling: each element held until its beat, 8 cycles to drain
    cycle(0, 32'h04030201, 1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 32'h0, 0, (i % 2) == 1);
    chk("toggle_drained_empty", 32'(DOTEN), 32'd0);

    // Accept into a full buffer in the cycle the head block retires
    cycle(0, 32'h14131211, 1, 0);
    cycle(0, 32'h24232221, 1, 0);
    chk("full_before_last", 32'(FULL), 32'd1);
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0, 1);
    chk("at_head_last", 32'(LAST), 32'd1);
    cycle(0, 32'h34333231, 1, 1);
    chk("full_after_swap", 32'(FULL), 32'd1);
    chk("no_ovf_on_swap", 32'(OVF), 32'd0);
    for (int i = 0; i < 9; i++) cycle(0, 32'h0, 0, 1);

    // Reset in the middle of a block
    cycle(0, 32'h04030201, 1, 1);
    cycle(0, 32'h0, 0, 1);
    cycle(0, 32'h0, 0, 1);
    chk("pre_reset_lane2", 32'(DOT), 32'd3);
    cycle(1, 32'h0, 0, 1);
    chk("post_reset_DOTEN", 32'(DOTEN), 32'd0);
    chk("post_reset_FULL", 32'(FULL), 32'd0);
    cycle(0, 32'h0C0B0A09, 1, 1);
    chk("fresh_first", 32'(DOT), 32'd9);
    for (int i = 0; i < 5; i++) cycle(0, 32'h0, 0, 1);

    // Overflow: third block dropped while stalled, only A and B drain
    drained = 0;
    cycle(0, 32'hA3A2A1A0, 1, 0);
    cycle(0, 32'hB3B2B1B0, 1, 0);
    chk("ovf_full_after_B", 32'(FULL), 32'd1);
    cycle(0, 32'hC3C2C1C0, 1, 0);
    chk("ovf_set_after_C", 32'(OVF), 32'd1);
    for (int i = 0; i < 10; i++) cycle(0, 32'h0, 0, 1);
    chk("ovf_drain_count", drained, 32'd8);
    chk("ovf_sticky", 32'(OVF), 32'd1);

    // Random traffic against the model
    cycle(1, 32'h0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      cycle(0, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 12; i++) cycle(0, 32'h0, 0, 1);
    chk("random_drained_empty", 32'(DOTEN), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
